// File: rtl/amplitude_rms_meter.sv
// Windowed peak-to-peak and integer AC RMS meter for an unsigned ADC stream.
// Optional feature: define AMP_RMS_AUTOZERO_EN to reference deviation to the window mean.
module amplitude_rms_meter #(
  parameter int SAMPLE_W = 12,
  parameter int LOG2_WIN = 10,
  parameter int MIDSCALE = 2048
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [31:0]         amplitude,
  output logic [31:0]         rms,
  output logic                result_valid,
  output logic                busy
);

  localparam int SQ_W  = 2 * SAMPLE_W;
  localparam int ACC_W = SQ_W + LOG2_WIN;
  localparam int REM_W = SAMPLE_W + 2;
  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  typedef enum logic [2:0] {IDLE, DIVIDE, DIVIDE2, SQRT, DONE} state_t;

  logic [LOG2_WIN-1:0] cnt_q;
  logic [SAMPLE_W-1:0] max_q, min_q, max_next, min_next;
  logic [ACC_W-1:0]    sumsq_q, sumsq_next;
  logic [SAMPLE_W-1:0] amp_snap_q;
  logic [SQ_W-1:0]     msq_snap_q;
  logic                win_close;

`ifdef AMP_RMS_AUTOZERO_EN
  localparam int SX_W = SAMPLE_W + LOG2_WIN;
  logic [SX_W-1:0]     sumx_q, sumx_next;
  logic [SAMPLE_W-1:0] mean_snap_q, mean_q;
  logic [SQ_W-1:0]     sq_w, sq, mean_w, mean_sq;
`else
  localparam logic [SAMPLE_W:0] MID_C = (SAMPLE_W + 1)'(MIDSCALE);
  logic signed [SAMPLE_W:0] dev;
  logic [SAMPLE_W:0]        mag;
  logic [SQ_W+1:0]          mag_w, sq;
`endif

  always_comb begin
    win_close = sample_valid && (cnt_q == '1);
    max_next  = (sample > max_q) ? sample : max_q;
    min_next  = (sample < min_q) ? sample : min_q;
`ifdef AMP_RMS_AUTOZERO_EN
    sq_w       = SQ_W'(sample);
    sq         = sq_w * sq_w;
    sumx_next  = sumx_q + SX_W'(sample);
    mean_w     = SQ_W'(mean_q);
    mean_sq    = mean_w * mean_w;
`else
    dev   = $signed({1'b0, sample}) - $signed(MID_C);
    mag   = dev[SAMPLE_W] ? unsigned'(-dev) : unsigned'(dev);
    mag_w = (SQ_W + 2)'(mag);
    sq    = mag_w * mag_w;
`endif
    sumsq_next = sumsq_q + ACC_W'(sq);
  end

  // Snapshots keep only the bits above LOG2_WIN, so the divide is a plain register load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      max_q       <= '0;
      min_q       <= '1;
      sumsq_q     <= '0;
      amp_snap_q  <= '0;
      msq_snap_q  <= '0;
`ifdef AMP_RMS_AUTOZERO_EN
      sumx_q      <= '0;
      mean_snap_q <= '0;
`endif
    end else if (sample_valid) begin
      cnt_q <= cnt_q + LOG2_WIN'(1);
      if (win_close) begin
        max_q       <= '0;
        min_q       <= '1;
        sumsq_q     <= '0;
        amp_snap_q  <= max_next - min_next;
        msq_snap_q  <= sumsq_next[ACC_W-1:LOG2_WIN];
`ifdef AMP_RMS_AUTOZERO_EN
        sumx_q      <= '0;
        mean_snap_q <= sumx_next[SX_W-1:LOG2_WIN];
`endif
      end else begin
        max_q   <= max_next;
        min_q   <= min_next;
        sumsq_q <= sumsq_next;
`ifdef AMP_RMS_AUTOZERO_EN
        sumx_q  <= sumx_next;
`endif
      end
    end
  end

  state_t              state_q;
  logic [SQ_W-1:0]     rad_q;
  logic [REM_W-1:0]    rem_q, rem_step;
  logic [SAMPLE_W-1:0] root_q, root_step;
  logic [CNT_W-1:0]    bit_q;
  logic [REM_W+1:0]    rem_sh, trial;
  logic                take;
  logic [31:0]         amp_q, rms_q;
  logic                valid_q, busy_q;

  // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
  always_comb begin
    rem_sh    = {rem_q, rad_q[SQ_W-1 -: 2]};
    trial     = (REM_W + 2)'({root_q, 2'b01});
    take      = (rem_sh >= trial);
    rem_step  = take ? REM_W'(rem_sh - trial) : REM_W'(rem_sh);
    root_step = {root_q[SAMPLE_W-2:0], take};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      bit_q   <= '0;
      amp_q   <= '0;
      rms_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef AMP_RMS_AUTOZERO_EN
      mean_q  <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_close) begin
            state_q <= DIVIDE;
            busy_q  <= 1'b1;
          end
        end
`ifdef AMP_RMS_AUTOZERO_EN
        DIVIDE: begin
          mean_q  <= mean_snap_q;
          state_q <= DIVIDE2;
        end
        DIVIDE2: begin
          rad_q   <= (msq_snap_q >= mean_sq) ? (msq_snap_q - mean_sq) : '0;
          rem_q   <= '0;
          root_q  <= '0;
          bit_q   <= CNT_W'(SAMPLE_W);
          state_q <= SQRT;
        end
`else
        DIVIDE: begin
          rad_q   <= msq_snap_q;
          rem_q   <= '0;
          root_q  <= '0;
          bit_q   <= CNT_W'(SAMPLE_W);
          state_q <= SQRT;
        end
`endif
        SQRT: begin
          rad_q  <= rad_q << 2;
          rem_q  <= rem_step;
          root_q <= root_step;
          bit_q  <= bit_q - CNT_W'(1);
          if (bit_q == CNT_W'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          amp_q   <= 32'(amp_snap_q);
          rms_q   <= 32'(root_q);
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign amplitude    = amp_q;
  assign rms          = rms_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_amplitude_rms_meter.sv
// Directed-vector bench for amplitude_rms_meter with hand-computed results.
module tb_amplitude_rms_meter;

  localparam int SW  = 12;
  localparam int WIN = 1024;
`ifdef AMP_RMS_AUTOZERO_EN
  localparam int LAT    = SW + 3;
  localparam int RMS_T3 = 0;
`else
  localparam int LAT    = SW + 2;
  localparam int RMS_T3 = 952;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample_valid;
  logic [SW-1:0] sample;
  logic [31:0]   amplitude, rms;
  logic          result_valid, busy;

  amplitude_rms_meter #(.SAMPLE_W(SW), .LOG2_WIN(10), .MIDSCALE(2048)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
    .amplitude(amplitude), .rms(rms), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0, failures = 0;
  int unsigned cyc = 0, last_edge = 0, pulse_n = 0, busy_n = 0;
  int unsigned p_cyc [16];
  logic [31:0] p_amp [16];
  logic [31:0] p_rms [16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (result_valid) begin
      if (pulse_n < 16) begin
        p_cyc[pulse_n] = cyc;
        p_amp[pulse_n] = amplitude;
        p_rms[pulse_n] = rms;
      end
      pulse_n++;
    end
    if (busy) busy_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [SW-1:0] v);
    sample_valid = 1'b1;
    sample       = v;
    @(posedge clk);
    #1;
    last_edge = cyc;
  endtask

  task automatic run_window(input logic [SW-1:0] a, input logic [SW-1:0] b);
    for (int i = 0; i < WIN; i++) send((i % 2 == 0) ? a : b);
  endtask

  task automatic idle_cycles(input int n);
    sample_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pulses(input string tag, input int unsigned target);
    sample_valid = 1'b0;
    for (int i = 0; i < 80 && pulse_n < target; i++) begin
      @(posedge clk);
      #1;
    end
    idle_cycles(3);
    chk(tag, 32'(pulse_n), 32'(target));
  endtask

  int unsigned n0;

  initial begin
    rst_n = 1'b0; sample_valid = 1'b0; sample = '0;
    idle_cycles(3);
    chk("rst_amp",   amplitude, 0);
    chk("rst_rms",   rms, 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    rst_n = 1'b1;
    idle_cycles(2);

    // 1: midscale constant
    n0 = pulse_n;
    run_window(12'd2048, 12'd2048);
    wait_pulses("t1_pulses", n0 + 1);
    chk("t1_amp", amplitude, 0);
    chk("t1_rms", rms, 0);

    // 2: +-1000 square wave, latency and busy width
    n0 = pulse_n; busy_n = 0;
    run_window(12'd1048, 12'd3048);
    n0 = n0 + 0;
    wait_pulses("t2_pulses", n0 + 1);
    chk("t2_amp", amplitude, 2000);
    chk("t2_rms", rms, 1000);
    chk("t2_latency", 32'(p_cyc[n0] - last_edge), 32'(LAT));
    chk("t2_busy_cycles", 32'(busy_n), 32'(LAT - 1));

    // 3: constant off midscale
    n0 = pulse_n;
    run_window(12'd3000, 12'd3000);
    wait_pulses("t3_pulses", n0 + 1);
    chk("t3_amp", amplitude, 0);
    chk("t3_rms", rms, 32'(RMS_T3));

    // 4: full-scale square wave
    n0 = pulse_n;
    run_window(12'd0, 12'd4095);
    wait_pulses("t4_pulses", n0 + 1);
    chk("t4_amp", amplitude, 4095);
    chk("t4_rms", rms, 2047);

    // 5: three back-to-back windows
    n0 = pulse_n;
    run_window(12'd1048, 12'd3048);
    run_window(12'd2048, 12'd2048);
    run_window(12'd0, 12'd4095);
    wait_pulses("t5_pulses", n0 + 3);
    chk("t5_amp0", p_amp[n0], 2000);
    chk("t5_rms0", p_rms[n0], 1000);
    chk("t5_amp1", p_amp[n0+1], 0);
    chk("t5_rms1", p_rms[n0+1], 0);
    chk("t5_amp2", p_amp[n0+2], 4095);
    chk("t5_rms2", p_rms[n0+2], 2047);
    chk("t5_gap01", 32'(p_cyc[n0+1] - p_cyc[n0]), 32'(WIN));
    chk("t5_gap12", 32'(p_cyc[n0+2] - p_cyc[n0+1]), 32'(WIN));

    // 6a: reset after a partial window
    for (int i = 0; i < 500; i++) send((i % 2 == 0) ? 12'd1048 : 12'd3048);
    rst_n = 1'b0;
    idle_cycles(2);
    chk("t6_rst_amp",   amplitude, 0);
    chk("t6_rst_rms",   rms, 0);
    chk("t6_rst_valid", 32'(result_valid), 0);
    rst_n = 1'b1;
    idle_cycles(1);
    n0 = pulse_n;
    run_window(12'd1548, 12'd2548);
    wait_pulses("t6_pulses", n0 + 1);
    chk("t6_amp", amplitude, 1000);
    chk("t6_rms", rms, 500);

    // 6b: reset while the square root is in progress
    n0 = pulse_n;
    run_window(12'd1048, 12'd3048);
    idle_cycles(5);
    chk("t6b_busy_sqrt", 32'(busy), 1);
    rst_n = 1'b0;
    idle_cycles(1);
    chk("t6b_rst_amp", amplitude, 0);
    rst_n = 1'b1;
    idle_cycles(40);
    chk("t6b_no_pulse", 32'(pulse_n), 32'(n0));
    chk("t6b_amp", amplitude, 0);
    chk("t6b_rms", rms, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
